// File: rtl/pu_ld_obuf_agen_mc_if.sv
// OBUF read-port bundle: beat request/accept, downstream space, and credit return.
// Latency: none, pure wiring between the address generator and the OBUF.
// Backpressure: mem_ready stalls the current beat; obuf_ld_stream_write_ready gates mem_req.
interface pu_ld_obuf_agen_mc_if #(
    parameter int MEM_AW = 9
);
    logic              mem_req;
    logic              mem_ready;
    logic [MEM_AW-1:0] mem_addr;
    logic              obuf_ld_stream_write_ready;
    logic              mem_resp_v;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  obuf_ld_stream_write_ready,
        input  mem_resp_v
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output obuf_ld_stream_write_ready,
        output mem_resp_v
    );
endinterface

// File: rtl/pu_ld_obuf_agen_mc.sv
// OBUF load address generator: nested-loop walker, NUM_FIFO sub-beats per address, credit-limited.
// Latency: mem_req eligible the cycle after start; done is a one-cycle pulse once all beats are acked.
// Backpressure: mem_addr holds while mem_ready=0; mem_req drops on no stream space or full credits.
// Optional stall counter enabled by defining PU_LD_OBUF_AGEN_PERF_EN.
module pu_ld_obuf_agen_mc #(
    parameter int ADDR_WIDTH      = 8,
    parameter int ADDR_STRIDE_W   = ADDR_WIDTH,
    parameter int LOOP_ITER_W     = 16,
    parameter int MAX_LOOPS       = 4,
    parameter int NUM_FIFO        = 2,
    parameter int FIFO_ID_W       = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     done,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
    input  logic                     cfg_loop_stride_v,
    input  logic [ADDR_STRIDE_W-1:0] cfg_loop_stride,
    pu_ld_obuf_agen_mc_if.master     mem,
    output logic                     busy,
    output logic [31:0]              perf_stall_cycles
);
    localparam int PTR_W = $clog2(MAX_LOOPS + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [LOOP_ITER_W-1:0]   iter_cfg   [MAX_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_cfg [MAX_LOOPS];
    logic [PTR_W-1:0]         iter_ptr, stride_ptr, iter_ptr_nxt, stride_ptr_nxt;
    logic [LOOP_ITER_W-1:0]   idx        [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   idx_nxt    [MAX_LOOPS];
    logic                     carry;
    logic                     walk_wrap;
    logic [ADDR_WIDTH-1:0]    base_q, loop_addr;
    logic [FIFO_ID_W-1:0]     fifo_id;
    logic [OUT_W-1:0]         outstanding;
    logic                     cfg_en, start_ok, fire, last_sub, resp_ok;

    assign cfg_en   = (state == S_IDLE);
    assign start_ok = cfg_en && start;
    assign busy     = (state != S_IDLE);

    // A cfg write coinciding with start counts toward the depth the walk uses.
    assign iter_ptr_nxt   = (cfg_en && cfg_loop_iter_v && iter_ptr != PTR_W'(MAX_LOOPS))
                            ? iter_ptr + PTR_W'(1) : iter_ptr;
    assign stride_ptr_nxt = (cfg_en && cfg_loop_stride_v && stride_ptr != PTR_W'(MAX_LOOPS))
                            ? stride_ptr + PTR_W'(1) : stride_ptr;

    assign mem.mem_req = (state == S_RUN) && mem.obuf_ld_stream_write_ready
                         && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign fire        = mem.mem_req && mem.mem_ready;
    assign last_sub    = (fifo_id == FIFO_ID_W'(NUM_FIFO - 1));
    assign resp_ok     = mem.mem_resp_v && (outstanding != '0);

    // Odometer step: innermost active level increments, carrying outward on wrap.
    always_comb begin
        carry = 1'b1;
        for (int k = MAX_LOOPS - 1; k >= 0; k--) begin
            idx_nxt[k] = idx[k];
            if ((PTR_W'(k) < iter_ptr) && carry) begin
                if (idx[k] == iter_cfg[k]) begin
                    idx_nxt[k] = '0;
                end else begin
                    idx_nxt[k] = idx[k] + LOOP_ITER_W'(1);
                    carry      = 1'b0;
                end
            end
        end
        walk_wrap = carry;
    end

    // Address = base + sum(idx*stride), modulo 2^ADDR_WIDTH; unwritten strides count as 0.
    always_comb begin
        loop_addr = base_q;
        for (int k = 0; k < MAX_LOOPS; k++) begin
            if (PTR_W'(k) < stride_ptr)
                loop_addr = loop_addr + (ADDR_WIDTH'(idx[k]) * ADDR_WIDTH'(stride_cfg[k]));
        end
    end

    if (NUM_FIFO > 1) begin : g_fid
        assign mem.mem_addr = {loop_addr, fifo_id};
    end else begin : g_nofid
        assign mem.mem_addr = loop_addr;
    end

    // Next-state logic for the walk sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (iter_ptr_nxt != '0) ? S_RUN : S_DONE;
            S_RUN:   if (fire && last_sub && walk_wrap) state_nxt = S_DRAIN;
            S_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and registered done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == S_DONE);
        end
    end

    // Loop configuration tables; pointers rewind as the walk completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_ptr   <= '0;
            stride_ptr <= '0;
            for (int k = 0; k < MAX_LOOPS; k++) begin
                iter_cfg[k]   <= '0;
                stride_cfg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAX_LOOPS; k++) begin
                if (cfg_en && cfg_loop_iter_v && PTR_W'(k) == iter_ptr)
                    iter_cfg[k] <= cfg_loop_iter;
                if (cfg_en && cfg_loop_stride_v && PTR_W'(k) == stride_ptr)
                    stride_cfg[k] <= cfg_loop_stride;
            end
            iter_ptr   <= (state == S_DONE) ? '0 : iter_ptr_nxt;
            stride_ptr <= (state == S_DONE) ? '0 : stride_ptr_nxt;
        end
    end

    // Walk position: sub-beat index plus per-level loop indices.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            fifo_id <= '0;
            for (int k = 0; k < MAX_LOOPS; k++) idx[k] <= '0;
        end else if (start_ok) begin
            base_q  <= base_addr;
            fifo_id <= '0;
            for (int k = 0; k < MAX_LOOPS; k++) idx[k] <= '0;
        end else if (fire) begin
            if (last_sub) begin
                fifo_id <= '0;
                for (int k = 0; k < MAX_LOOPS; k++) idx[k] <= idx_nxt[k];
            end else begin
                fifo_id <= fifo_id + FIFO_ID_W'(1);
            end
        end
    end

    // Outstanding-beat credit counter; a response with nothing outstanding is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({fire, resp_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef PU_LD_OBUF_AGEN_PERF_EN
    // Saturating count of RUN cycles that did not issue a beat.
    always_ff @(posedge clk) begin
        if (reset || start_ok)
            perf_stall_cycles <= '0;
        else if (state == S_RUN && !fire && perf_stall_cycles != '1)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pu_ld_obuf_agen_mc.sv
// Scoreboard bench for the OBUF load address generator (NUM_FIFO=2, MAX_OUTSTANDING=2).
// Stimulus pushes expected {loop_addr, fifo_id} beats; a negedge monitor pops on every fire.
// Directed walks cover stride walk, nested loops, stalls, credit limit, zero-loop, reset, wrap.
module tb_pu_ld_obuf_agen_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [7:0]  base_addr;
    logic        cfg_loop_iter_v;
    logic [15:0] cfg_loop_iter;
    logic        cfg_loop_stride_v;
    logic [7:0]  cfg_loop_stride;
    logic        busy;
    logic [31:0] perf_stall_cycles;

    pu_ld_obuf_agen_mc_if #(.MEM_AW(9)) mif();

    pu_ld_obuf_agen_mc #(
        .ADDR_WIDTH(8), .NUM_FIFO(2), .MAX_OUTSTANDING(2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .done              (done),
        .base_addr         (base_addr),
        .cfg_loop_iter_v   (cfg_loop_iter_v),
        .cfg_loop_iter     (cfg_loop_iter),
        .cfg_loop_stride_v (cfg_loop_stride_v),
        .cfg_loop_stride   (cfg_loop_stride),
        .mem               (mif),
        .busy              (busy),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         fire_cnt = 0;
    int         done_cnt = 0;
    int         req_cnt  = 0;
    bit         fire_flag = 1'b0;
    bit         auto_resp = 1'b0;
    bit         man_resp  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [15:0] it, input logic [7:0] st);
        cfg_loop_iter_v   = 1'b1;
        cfg_loop_iter     = it;
        cfg_loop_stride_v = 1'b1;
        cfg_loop_stride   = st;
        tick(1);
        cfg_loop_iter_v   = 1'b0;
        cfg_loop_stride_v = 1'b0;
    endtask

    task automatic push_addr(input logic [7:0] a);
        exp_q.push_back({a, 1'b0});
        exp_q.push_back({a, 1'b1});
    endtask

    task automatic do_start(input logic [7:0] b);
        base_addr = b;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < bound) begin
            tick(1);
            n++;
        end
        tick(3);
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: every fired beat is matched against the head of the expected queue.
    initial forever begin
        logic [8:0] e;
        @(negedge clk);
        fire_flag = 1'b0;
        if (!reset) begin
            if (done) done_cnt++;
            if (mif.mem_req) req_cnt++;
            if (mif.mem_req && mif.mem_ready) begin
                fire_flag = 1'b1;
                fire_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected got %0h want none", mif.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (mif.mem_addr !== e) begin
                        errors++;
                        $display("FAIL beat_addr got %0h want %0h", mif.mem_addr, e);
                    end
                end
            end
        end
    end

    // Responder: acknowledge each beat one cycle after it fires, or follow man_resp.
    initial forever begin
        @(posedge clk);
        #2;
        mif.mem_resp_v = auto_resp ? fire_flag : man_resp;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  f0;
        int  d0;
        int  r0;
        bit  found;
        reset = 1'b1; start = 1'b0; base_addr = '0;
        cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0;
        cfg_loop_stride_v = 1'b0; cfg_loop_stride = '0;
        mif.mem_ready = 1'b1;
        mif.obuf_ld_stream_write_ready = 1'b1;
        mif.mem_resp_v = 1'b0;
        tick(3);
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_perf", perf_stall_cycles, 0);
        reset = 1'b0;
        tick(1);

        // Single loop, base 0x10, iter=3, stride 2.
        auto_resp = 1'b1;
        cfg_write(16'd3, 8'd2);
        push_addr(8'h10); push_addr(8'h12); push_addr(8'h14); push_addr(8'h16);
        f0 = fire_cnt;
        do_start(8'h10);
        chk("t1_busy", busy, 1);
        wait_done("t1", 200);
        chk("t1_fires", fire_cnt - f0, 8);

        // Two loops; inner level written in the same cycle as start.
        cfg_write(16'd1, 8'h20);
        push_addr(8'h00); push_addr(8'h01); push_addr(8'h02);
        push_addr(8'h20); push_addr(8'h21); push_addr(8'h22);
        f0 = fire_cnt;
        cfg_loop_iter_v = 1'b1; cfg_loop_iter = 16'd2;
        cfg_loop_stride_v = 1'b1; cfg_loop_stride = 8'd1;
        do_start(8'h00);
        cfg_loop_iter_v = 1'b0; cfg_loop_stride_v = 1'b0;
        wait_done("t2", 200);
        chk("t2_fires", fire_cnt - f0, 12);

        // mem_ready stall on {12,1}, then stream-space stall.
        cfg_write(16'd3, 8'd2);
        push_addr(8'h10); push_addr(8'h12); push_addr(8'h14); push_addr(8'h16);
        f0 = fire_cnt;
        do_start(8'h10);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mif.mem_addr == 9'h025 && busy) found = 1'b1;
            else tick(1);
        end
        chk("t3_found_beat", found, 1);
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t3_addr_hold", mif.mem_addr, 9'h025);
        end
        mif.mem_ready = 1'b1;
        tick(1);
        mif.obuf_ld_stream_write_ready = 1'b0;
        #1;
        chk("t3_wr_rdy_drop", mif.mem_req, 0);
        tick(2);
        chk("t3_wr_rdy_hold", mif.mem_req, 0);
        mif.obuf_ld_stream_write_ready = 1'b1;
        wait_done("t3", 200);
        chk("t3_fires", fire_cnt - f0, 8);

        // Credit limit: responses under manual control; stray responses in IDLE ignored.
        auto_resp = 1'b0;
        man_resp = 1'b1;
        tick(2);
        man_resp = 1'b0;
        cfg_write(16'd1, 8'd4);
        push_addr(8'h40); push_addr(8'h44);
        f0 = fire_cnt;
        do_start(8'h40);
        tick(6);
        chk("t4_cap_fires", fire_cnt - f0, 2);
        chk("t4_cap_req", mif.mem_req, 0);
        man_resp = 1'b1;
        tick(1);
        man_resp = 1'b0;
        tick(5);
        chk("t4_one_credit_fires", fire_cnt - f0, 3);
        chk("t4_one_credit_req", mif.mem_req, 0);
        d0 = done_cnt;
        man_resp = 1'b1;
        tick(2);
        man_resp = 1'b0;
        tick(5);
        chk("t4_simul_fires", fire_cnt - f0, 4);
        chk("t4_drain_no_done", done_cnt - d0, 0);
        chk("t4_drain_busy", busy, 1);
        man_resp = 1'b1;
        tick(1);
        man_resp = 1'b0;
        wait_done("t4", 50);

        // Zero-loop start: done two cycles after start, no requests.
        f0 = fire_cnt;
        r0 = req_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t5_done_c1", done, 0);
        tick(1);
        chk("t5_done_c2", done, 1);
        tick(1);
        chk("t5_done_c3", done, 0);
        chk("t5_no_req", req_cnt - r0, 0);
        chk("t5_no_fire", fire_cnt - f0, 0);

        // Reset in the middle of a walk.
        mif.mem_ready = 1'b0;
        cfg_write(16'd3, 8'd1);
        do_start(8'h80);
        tick(2);
        chk("t6_busy_pre", busy, 1);
        d0 = done_cnt;
        reset = 1'b1;
        tick(1);
        chk("t6_req_after_rst", mif.mem_req, 0);
        chk("t6_busy_after_rst", busy, 0);
        reset = 1'b0;
        mif.mem_ready = 1'b1;
        tick(4);
        chk("t6_no_done", done_cnt - d0, 0);

        // Restart after reset: address wrap and two injected stall cycles.
        auto_resp = 1'b1;
        cfg_write(16'd3, 8'd1);
        push_addr(8'hFE); push_addr(8'hFF); push_addr(8'h00); push_addr(8'h01);
        f0 = fire_cnt;
        mif.mem_ready = 1'b0;
        do_start(8'hFE);
        tick(2);
        mif.mem_ready = 1'b1;
        wait_done("t7", 200);
        chk("t7_fires", fire_cnt - f0, 8);
`ifdef PU_LD_OBUF_AGEN_PERF_EN
        chk("t7_perf_stalls", perf_stall_cycles, 2);
`else
        chk("t7_perf_tied", perf_stall_cycles, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
